// File: rtl/store_merge_unit.sv
// ============================================================================
// store_merge_unit
//   Narrows a 32-bit store to word/half/byte and writes it into a word-only
//   data memory; sub-word stores are done by read-modify-write.
//   Optional feature macro: ALIGN_CHECK_EN (misaligned half/word -> Error).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_merge_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  StartStore,
    input  logic [1:0]            StoreSize,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemReadEn,
    input  logic [31:0]           MemReadData,
    output logic                  MemWriteEn,
    output logic [31:0]           MemWriteData
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_BYTE = 2'b10;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [1:0]            r_size;
    logic [1:0]            r_off;
    logic [15:0]           r_src;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_is_word;
    logic                  w_misalign;
    logic                  w_accept;
    logic [31:0]           w_mask;
    logic [31:0]           w_lane;
    logic [31:0]           w_merged;

    // Reserved size 2'b11 is handled as a full word.
    assign w_is_word = (StoreSize != c_SIZE_HALF) && (StoreSize != c_SIZE_BYTE);
    assign w_accept  = (r_state == S_IDLE) && StartStore;

`ifdef ALIGN_CHECK_EN
    logic r_err;

    assign w_misalign = ((StoreSize == c_SIZE_HALF) && Address[0]) ||
                        (w_is_word && (Address[1:0] != 2'b00));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (StartStore) begin
                    if (w_misalign) begin
                        w_next = S_DONE;
                    end else if (w_is_word) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ:  w_next = S_MERGE;
            S_MERGE: w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        Busy       = (r_state == S_READ) || (r_state == S_MERGE) || (r_state == S_WRITE);
        Done       = (r_state == S_DONE);
        MemReadEn  = (r_state == S_READ);
        MemWriteEn = (r_state == S_WRITE);
`ifdef ALIGN_CHECK_EN
        Error      = (r_state == S_DONE) && r_err;
`else
        Error      = 1'b0;
`endif
    end

    // Big-endian lanes: byte offset 0 is bits [31:24]; half lane picked by offset[1].
    always_comb begin
        w_mask = 32'h0000_0000;
        w_lane = 32'h0000_0000;
        if (r_size == c_SIZE_BYTE) begin
            w_mask = 32'hFF00_0000 >> {r_off, 3'b000};
            w_lane = {4{r_src[7:0]}};
        end else begin
            w_mask = r_off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
            w_lane = {2{r_src[15:0]}};
        end
        w_merged = (MemReadData & ~w_mask) | (w_lane & w_mask);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_off   <= 2'b00;
            r_src   <= 16'h0000;
            r_wdata <= 32'h0000_0000;
        end else if (w_accept) begin
            r_addr  <= {Address[ADDR_WIDTH-1:2], 2'b00};
            r_size  <= StoreSize;
            r_off   <= Address[1:0];
            r_src   <= WriteData[15:0];
            r_wdata <= WriteData;
        end else if (r_state == S_MERGE) begin
            r_wdata <= w_merged;
        end
    end

    assign MemAddress   = r_addr;
    assign MemWriteData = r_wdata;

endmodule

`default_nettype wire
